// File: rtl/screen_blitter.sv
// Rectangle blitter: sweeps WIDTH x HEIGHT at (X0,Y0) and streams one ROM pixel per clock to vga_adapter.
// Optional sprite mode: define BLIT_TRANSPARENT_EN to suppress PLOT for pixels equal to KEY_COLOUR.
module screen_blitter #(
    parameter int WIDTH       = 160,
    parameter int HEIGHT      = 120,
    parameter int X_BITS      = 8,
    parameter int Y_BITS      = 7,
    parameter int COLOUR_BITS = 3,
    parameter int NUM_SCREENS = 4,
    parameter int ADDR_BITS   = 15,
    parameter int SEL_BITS    = 2,
    parameter int KEY_COLOUR  = 0
) (
    input  logic                               CLOCK_50,
    input  logic                               RESETN,
    input  logic                               START,
    input  logic [SEL_BITS-1:0]                SCREEN_SEL,
    input  logic [X_BITS-1:0]                  X0,
    input  logic [Y_BITS-1:0]                  Y0,
    output logic [ADDR_BITS-1:0]               ROM_ADDR,
    input  logic [NUM_SCREENS*COLOUR_BITS-1:0] ROM_DATA,
    output logic [X_BITS-1:0]                  VGA_X,
    output logic [Y_BITS-1:0]                  VGA_Y,
    output logic [COLOUR_BITS-1:0]             COLOUR,
    output logic                               PLOT,
    output logic                               BUSY,
    output logic                               DONE
);

    // state   | meaning
    // S_IDLE  | waiting for START, latches SEL/X0/Y0 on accept
    // S_DRAW  | one ROM address per clock in raster order
    // S_FLUSH | last pixel's ROM data returns and is plotted
    // S_DONE  | one-cycle DONE pulse, then back to idle

    localparam int XC_BITS = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YC_BITS = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [XC_BITS-1:0]     XC_LAST = XC_BITS'(WIDTH - 1);
    localparam logic [YC_BITS-1:0]     YC_LAST = YC_BITS'(HEIGHT - 1);
    localparam logic [COLOUR_BITS-1:0] KEY_C   = COLOUR_BITS'(KEY_COLOUR);
`ifdef BLIT_TRANSPARENT_EN
    localparam bit TRANSPARENT = 1'b1;
`else
    localparam bit TRANSPARENT = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAW  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    logic [XC_BITS-1:0]      r_xc;
    logic [YC_BITS-1:0]      r_yc;
    logic [ADDR_BITS-1:0]    r_addr;
    logic [SEL_BITS-1:0]     r_sel;
    logic [X_BITS-1:0]       r_x0;
    logic [Y_BITS-1:0]       r_y0;
    logic [X_BITS-1:0]       r_vga_x;
    logic [Y_BITS-1:0]       r_vga_y;
    logic                    r_plot;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_last;
    logic [COLOUR_BITS-1:0]  w_colour;
    logic                    w_is_key;

    assign w_last = (r_xc == XC_LAST) && (r_yc == YC_LAST);

    // r_addr tracks yc*WIDTH+xc incrementally, so no multiplier is needed for arbitrary WIDTH.
    always_ff @(posedge CLOCK_50) begin
        if (!RESETN) begin
            r_state <= S_IDLE;
            r_xc    <= '0;
            r_yc    <= '0;
            r_addr  <= '0;
            r_sel   <= '0;
            r_x0    <= '0;
            r_y0    <= '0;
            r_vga_x <= '0;
            r_vga_y <= '0;
            r_plot  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_plot  <= (r_state == S_DRAW);
            r_vga_x <= r_x0 + X_BITS'(r_xc);
            r_vga_y <= r_y0 + Y_BITS'(r_yc);
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_sel   <= SCREEN_SEL;
                        r_x0    <= X0;
                        r_y0    <= Y0;
                        r_xc    <= '0;
                        r_yc    <= '0;
                        r_addr  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (w_last) begin
                        r_xc    <= '0;
                        r_yc    <= '0;
                        r_addr  <= '0;
                        r_state <= S_FLUSH;
                    end else begin
                        r_addr <= r_addr + ADDR_BITS'(1);
                        if (r_xc == XC_LAST) begin
                            r_xc <= '0;
                            r_yc <= r_yc + YC_BITS'(1);
                        end else begin
                            r_xc <= r_xc + XC_BITS'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ROM data already carries one cycle of latency, which lines it up with the registered outputs.
    always_comb begin
        w_colour = '0;
        for (int i = 0; i < NUM_SCREENS; i++) begin
            if (r_sel == SEL_BITS'(i)) begin
                w_colour = ROM_DATA[i*COLOUR_BITS +: COLOUR_BITS];
            end
        end
    end

    assign w_is_key = (w_colour == KEY_C);

    assign ROM_ADDR = r_addr;
    assign VGA_X    = r_vga_x;
    assign VGA_Y    = r_vga_y;
    assign COLOUR   = w_colour;
    assign PLOT     = r_plot && !(TRANSPARENT && w_is_key);
    assign BUSY     = r_busy;
    assign DONE     = r_done;

endmodule

// File: tb/tb_screen_blitter.sv
// Scoreboard bench for screen_blitter: a 4x2 instance checked pixel by pixel, plus a 1x1 instance.
// Honours BLIT_TRANSPARENT_EN in the reference model when the macro is defined.
module tb_screen_blitter;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int CB = 6;

    logic          CLOCK_50;
    logic          RESETN;
    logic          START;
    logic [1:0]    SCREEN_SEL;
    logic [7:0]    X0;
    logic [6:0]    Y0;

    logic [14:0]   ROM_ADDR, ROM_ADDR1;
    logic [4*CB-1:0] ROM_DATA, ROM_DATA1;
    logic [7:0]    VGA_X, VGA_X1;
    logic [6:0]    VGA_Y, VGA_Y1;
    logic [CB-1:0] COLOUR, COLOUR1;
    logic          PLOT, BUSY, DONE;
    logic          PLOT1, BUSY1, DONE1;

    screen_blitter #(.WIDTH(W), .HEIGHT(H), .COLOUR_BITS(CB)) dut (
        .CLOCK_50(CLOCK_50), .RESETN(RESETN), .START(START), .SCREEN_SEL(SCREEN_SEL),
        .X0(X0), .Y0(Y0), .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA), .VGA_X(VGA_X),
        .VGA_Y(VGA_Y), .COLOUR(COLOUR), .PLOT(PLOT), .BUSY(BUSY), .DONE(DONE));

    screen_blitter #(.WIDTH(1), .HEIGHT(1), .COLOUR_BITS(CB)) dut1 (
        .CLOCK_50(CLOCK_50), .RESETN(RESETN), .START(START), .SCREEN_SEL(SCREEN_SEL),
        .X0(X0), .Y0(Y0), .ROM_ADDR(ROM_ADDR1), .ROM_DATA(ROM_DATA1), .VGA_X(VGA_X1),
        .VGA_Y(VGA_Y1), .COLOUR(COLOUR1), .PLOT(PLOT1), .BUSY(BUSY1), .DONE(DONE1));

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    // ROMs: registered address, ROM i returns addr+16*i (the 1x1 instance adds 1 so it is never the key).
    logic [14:0] rom_q, rom1_q;
    always @(posedge CLOCK_50) begin
        rom_q  <= ROM_ADDR;
        rom1_q <= ROM_ADDR1;
    end
    always_comb begin
        ROM_DATA  = '0;
        ROM_DATA1 = '0;
        for (int i = 0; i < 4; i++) begin
            ROM_DATA[i*CB +: CB]  = rom_q[CB-1:0] + CB'(16*i);
            ROM_DATA1[i*CB +: CB] = rom1_q[CB-1:0] + CB'(16*i + 1);
        end
    end

    typedef struct {
        bit is_done;
        int x;
        int y;
        int c;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_plot = 0;
    int busy_cnt = 0;
    int n_plots = 0;
    int done_count = 0;
    int p1_cnt = 0;
    int b1_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a blit is the raster sweep of the rectangle, followed by one DONE.
    task automatic push_blit(input int sel, input int x0, input int y0);
        exp_t e;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                e.is_done = 1'b0;
                e.x = (x0 + x) % 256;
                e.y = (y0 + y) % 128;
                e.c = (y * W + x + 16 * sel) % 64;
`ifdef BLIT_TRANSPARENT_EN
                if (e.c != 0) sb.push_back(e);
`else
                sb.push_back(e);
`endif
            end
        end
        e.is_done = 1'b1;
        e.x = 0;
        e.y = 0;
        e.c = 0;
        sb.push_back(e);
    endtask

    // Monitor: samples on the falling edge, where RESETN equals what the last rising edge saw.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLOCK_50);
            cyc++;
            if (!RESETN) begin
                chk("rst_plot", int'(PLOT), 0);
                chk("rst_busy", int'(BUSY), 0);
                chk("rst_done", int'(DONE), 0);
                chk("rst_vga_x", int'(VGA_X), 0);
                chk("rst_vga_y", int'(VGA_Y), 0);
                chk("rst_rom_addr", int'(ROM_ADDR), 0);
                chk("rst1_busy", int'(BUSY1), 0);
                sb.delete();
                busy_cnt = 0;
                p1_cnt = 0;
                b1_cnt = 0;
            end else begin
                if (BUSY) busy_cnt++;
                if (PLOT) begin
                    n_plots++;
                    last_plot = cyc;
                    if (sb.size() == 0) begin
                        chk("unexpected_plot", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("plot_not_done_slot", int'(e.is_done), 0);
                        if (!e.is_done) begin
                            chk("vga_x", int'(VGA_X), e.x);
                            chk("vga_y", int'(VGA_Y), e.y);
                            chk("colour", int'(COLOUR), e.c);
                        end
                    end
                end
                if (DONE) begin
                    done_count++;
                    chk("done_plot_low", int'(PLOT), 0);
                    chk("done_after_last_plot", cyc - last_plot, 1);
                    chk("busy_cycles", busy_cnt, W * H + 1);
                    busy_cnt = 0;
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("done_order", int'(e.is_done), 1);
                    end
                end
                if (BUSY1) b1_cnt++;
                if (PLOT1) p1_cnt++;
                if (DONE1) begin
                    chk("w1_plot_count", p1_cnt, 1);
                    chk("w1_busy_cycles", b1_cnt, 2);
                    chk("w1_done_plot_low", int'(PLOT1), 0);
                    p1_cnt = 0;
                    b1_cnt = 0;
                end
            end
        end
    end

    task automatic tick();
        @(negedge CLOCK_50);
        #1;
    endtask

    task automatic wait_busy();
        int t;
        t = 0;
        while (!BUSY && t < 20) begin
            tick();
            t++;
        end
        if (!BUSY) chk("busy_timeout", 0, 1);
    endtask

    task automatic wait_done(input int target);
        int t;
        t = 0;
        while (done_count < target && t < 100) begin
            tick();
            t++;
        end
        if (done_count < target) chk("done_timeout", done_count, target);
    endtask

    task automatic blit(input int sel, input int x0, input int y0);
        int target;
        target = done_count + 1;
        push_blit(sel, x0, y0);
        SCREEN_SEL = 2'(sel);
        X0 = 8'(x0);
        Y0 = 7'(y0);
        START = 1'b1;
        tick();
        wait_busy();
        START = 1'b0;
        SCREEN_SEL = 2'($urandom);
        X0 = 8'($urandom);
        Y0 = 7'($urandom);
        wait_done(target);
        repeat ($urandom_range(0, 2)) tick();
    endtask

    initial begin
        int target;
        int base;
        int t;
        RESETN = 1'b0;
        START = 1'b0;
        SCREEN_SEL = '0;
        X0 = '0;
        Y0 = '0;
        repeat (3) tick();
        RESETN = 1'b1;
        tick();

        blit(2, 10, 5);
        blit(1, 255, 127);
        blit(0, 20, 30);

        // START held throughout, SEL changed mid-blit: only the latched value counts.
        target = done_count + 1;
        push_blit(1, 40, 50);
        push_blit(3, 40, 50);
        SCREEN_SEL = 2'd1;
        X0 = 8'd40;
        Y0 = 7'd50;
        START = 1'b1;
        tick();
        wait_busy();
        SCREEN_SEL = 2'd3;
        wait_done(target);
        tick();
        wait_busy();
        START = 1'b0;
        SCREEN_SEL = 2'd0;
        wait_done(target + 1);
        tick();

        // Reset after the third pixel aborts the blit; the next one restarts at the origin.
        base = n_plots;
        push_blit(3, 100, 60);
        SCREEN_SEL = 2'd3;
        X0 = 8'd100;
        Y0 = 7'd60;
        START = 1'b1;
        tick();
        wait_busy();
        START = 1'b0;
        t = 0;
        while (n_plots < base + 3 && t < 20) begin
            tick();
            t++;
        end
        chk("mid_reset_plots_seen", n_plots - base, 3);
        RESETN = 1'b0;
        tick();
        RESETN = 1'b1;
        tick();
        blit(3, 100, 60);

        for (int i = 0; i < 15; i++) begin
            blit(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), int'($urandom_range(0, 127)));
        end

        repeat (4) tick();
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
